// File: rtl/ps2_mouse_ctrl_pkg.sv
// Shared constants, state encoding and response decoding for the PS/2 mouse controller.
package ps2_pkg;
  localparam logic [7:0] CMD_RESET  = 8'hFF;
  localparam logic [7:0] CMD_ENABLE = 8'hF4;
  localparam logic [7:0] RSP_ACK    = 8'hFA;
  localparam logic [7:0] RSP_RESEND = 8'hFE;
  localparam logic [7:0] RSP_BAT_OK = 8'hAA;
  localparam logic [7:0] MOUSE_ID   = 8'h00;

  localparam logic [1:0] REG_BTN  = 2'd0;
  localparam logic [1:0] REG_X    = 2'd1;
  localparam logic [1:0] REG_Y    = 2'd2;
  localparam logic [1:0] REG_STAT = 2'd3;

  typedef enum logic [2:0] {
    SEND_RST, WAIT_ACK1, WAIT_BAT, WAIT_ID, SEND_EN, WAIT_ACK2, STREAM
  } state_t;

  // Next state for a byte received in one of the WAIT states.
  function automatic state_t wait_next(state_t s, logic [7:0] b);
    state_t n;
    n = SEND_RST;
    case (s)
      WAIT_ACK1: if (b == RSP_ACK) n = WAIT_BAT;
      WAIT_BAT:  if (b == RSP_BAT_OK) n = WAIT_ID;
      WAIT_ID:   if (b == MOUSE_ID) n = SEND_EN;
      WAIT_ACK2: begin
        if (b == RSP_ACK) n = STREAM;
        else if (b == RSP_RESEND) n = SEND_EN;
      end
      default: n = SEND_RST;
    endcase
    return n;
  endfunction
endpackage

// File: rtl/ps2_mouse_ctrl_if.sv
// Byte-level link between the controller and the PS/2 transceiver.
interface ps2_mouse_ctrl_if;
  logic [7:0] tx_byte;
  logic       tx_req;
  logic       tx_busy;
  logic       tx_done;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_err;

  modport master (output tx_byte, tx_req,
                  input  tx_busy, tx_done, rx_byte, rx_valid, rx_err);
  modport slave  (input  tx_byte, tx_req,
                  output tx_busy, tx_done, rx_byte, rx_valid, rx_err);
endinterface

// File: rtl/ps2_mouse_ctrl_axis_accum.sv
// Saturating position update for one axis: clamp(pos +/- delta, 0, MAX).
module ps2_axis_accum #(
  parameter int MAX = 255
) (
  input  logic [7:0] pos,
  input  logic [8:0] delta,
  input  logic       negate,
  output logic [7:0] next_pos
);
  localparam logic signed [9:0] MAX10 = 10'(MAX);

  logic signed [9:0] d;
  logic signed [9:0] sum;

  // 10 bits covers 0..255 plus/minus 256 without wrap.
  always_comb begin
    d   = signed'({delta[8], delta});
    sum = signed'({2'b00, pos}) + (negate ? -d : d);
    if (sum[9])           next_pos = 8'd0;
    else if (sum > MAX10) next_pos = MAX10[7:0];
    else                  next_pos = sum[7:0];
  end
endmodule

// File: rtl/ps2_mouse_ctrl.sv
// PS/2 mouse init sequencer, packet assembler and CPU-readable position/button registers.
module ps2_mouse_ctrl #(
  parameter int X_MAX       = 255,
  parameter int Y_MAX       = 255,
  parameter int TIMEOUT_CYC = 2_000_000,
  parameter int PKT_GAP_CYC = 100_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             io_cs,
  input  logic [1:0]       addr,
  output logic [7:0]       data,
  output logic             dav,
  output logic             ready,
  ps2_mouse_ctrl_if.master xcvr
);
  import ps2_pkg::*;

  localparam logic [31:0] TO_LOAD  = 32'(TIMEOUT_CYC);
  localparam logic [31:0] GAP_LIM  = 32'(PKT_GAP_CYC);

  state_t      state;
  logic        sent, err;
  logic [1:0]  idx;
  logic [7:0]  b0, b1, x, y, rd;
  logic [2:0]  btn;
  logic [31:0] timer, gap;
  logic [8:0]  dx, dy;
  logic [7:0]  x_nxt, y_nxt;

  // Overflowed axes contribute no movement; byte 2 is applied straight from rx_byte.
  assign dx = b0[6] ? 9'd0 : {b0[4], b1};
  assign dy = b0[7] ? 9'd0 : {b0[5], xcvr.rx_byte};

  ps2_axis_accum #(.MAX(X_MAX)) u_x (.pos(x), .delta(dx), .negate(1'b0), .next_pos(x_nxt));
  ps2_axis_accum #(.MAX(Y_MAX)) u_y (.pos(y), .delta(dy), .negate(1'b1), .next_pos(y_nxt));

  always_comb begin
    rd = 8'd0;
    case (addr)
      REG_BTN: rd = {5'b0, btn};
      REG_X:   rd = x;
      REG_Y:   rd = y;
      default: rd = {6'b0, err, ready};
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= SEND_RST;
      sent         <= 1'b0;
      err          <= 1'b0;
      ready        <= 1'b0;
      dav          <= 1'b0;
      data         <= 8'd0;
      xcvr.tx_req  <= 1'b0;
      xcvr.tx_byte <= 8'd0;
      idx          <= 2'd0;
      b0           <= 8'd0;
      b1           <= 8'd0;
      btn          <= 3'd0;
      x            <= 8'(X_MAX / 2);
      y            <= 8'(Y_MAX / 2);
      timer        <= 32'd0;
      gap          <= 32'd0;
    end else begin
      xcvr.tx_req <= 1'b0;
      dav         <= 1'b0;
      if (io_cs) data <= rd;
      case (state)
        SEND_RST, SEND_EN: begin
          if (!sent) begin
            if (!xcvr.tx_busy) begin
              xcvr.tx_req  <= 1'b1;
              xcvr.tx_byte <= (state == SEND_RST) ? CMD_RESET : CMD_ENABLE;
              sent         <= 1'b1;
            end
          end else if (xcvr.tx_done) begin
            sent  <= 1'b0;
            timer <= TO_LOAD;
            state <= (state == SEND_RST) ? WAIT_ACK1 : WAIT_ACK2;
          end
        end
        STREAM: begin
          if (xcvr.rx_err) begin
            idx <= 2'd0;
            gap <= 32'd0;
          end else if (xcvr.rx_valid) begin
            gap <= 32'd0;
            case (idx)
              2'd0: if (xcvr.rx_byte[3]) begin b0 <= xcvr.rx_byte; idx <= 2'd1; end
              2'd1: begin b1 <= xcvr.rx_byte; idx <= 2'd2; end
              default: begin
                x   <= x_nxt;
                y   <= y_nxt;
                btn <= b0[2:0];
                dav <= 1'b1;
                idx <= 2'd0;
              end
            endcase
          end else if (idx != 2'd0) begin
            if (gap >= GAP_LIM) begin
              idx <= 2'd0;
              gap <= 32'd0;
            end else begin
              gap <= gap + 32'd1;
            end
          end
        end
        default: begin
          // A received byte takes precedence over a timeout on the same edge.
          timer <= timer - 32'd1;
          if (xcvr.rx_err) begin
            state <= SEND_RST;
          end else if (xcvr.rx_valid) begin
            timer <= TO_LOAD;
            state <= wait_next(state, xcvr.rx_byte);
            if (wait_next(state, xcvr.rx_byte) == STREAM) begin
              ready <= 1'b1;
              err   <= 1'b0;
              idx   <= 2'd0;
              gap   <= 32'd0;
            end
          end else if (timer == 32'd0) begin
            state <= SEND_RST;
            err   <= 1'b1;
          end
        end
      endcase
    end
  end
endmodule

// File: doc/ps2_mouse_ctrl.md
# ps2_mouse_ctrl

Sequencing controller for the PS/2 mouse path. It sits between a byte-level PS/2 transceiver (bit framing, parity, clock/data open-drain handling) and the CPU I/O bus. It runs the mouse initialisation handshake (reset, self-test, enable reporting) and recovers from resend, error and timeout conditions. In streaming mode it assembles 3-byte movement packets and keeps a saturating 8-bit screen position and button state that the CPU reads through `io_cs`/`addr`.

## Interface
- `X_MAX`, 255, upper bound of X position (≤255)
- `Y_MAX`, 255, upper bound of Y position (≤255)
- `TIMEOUT_CYC`, 2_000_000, init-phase wait limit, in clk cycles
- `PKT_GAP_CYC`, 100_000, maximum idle gap between bytes of one packet
- `clk` in 1 system clock
- `rst` in 1 reset; one clock domain, synchronous, active-low
- `io_cs` in 1 register read strobe
- `addr` in 2 register select
- `data` out 8 registered read data
- `dav` out 1 one-cycle pulse: new packet applied
- `ready` out 1 init complete, streaming
- `tx_byte` out 8 command byte to transceiver
- `tx_req` out 1 one-cycle send request
- `tx_busy` in 1 transceiver sending
- `tx_done` in 1 one-cycle pulse: mouse acknowledged the frame
- `rx_byte` in 8 received byte
- `rx_valid` in 1 one-cycle pulse: `rx_byte` valid
- `rx_err` in 1 one-cycle pulse: parity or frame error

## Operation
- States: SEND_RST → WAIT_ACK1 → WAIT_BAT → WAIT_ID → SEND_EN → WAIT_ACK2 → STREAM.
- SEND_x: waits for `tx_busy`=0, pulses `tx_req` with `tx_byte` (0xFF reset, 0xF4 enable), then waits for `tx_done` before moving on.
- WAIT_ACK1/2:
  - 0xFA → next state.
  - 0xFE → return to the same SEND state (resend).
  - Any other byte or `rx_err` → SEND_RST.
- WAIT_BAT: 0xAA → WAIT_ID. Anything else, including 0xFC → SEND_RST.
- WAIT_ID: 0x00 → SEND_EN. Anything else → SEND_RST.
- Timeout: each WAIT state loads a counter with `TIMEOUT_CYC`. On expiry: go to SEND_RST and set sticky `err`. `err` clears when STREAM is entered.
- STREAM, byte index 0..2:
  - Byte 0 with bit3=0 is discarded and the index stays at 0 (resync).
  - `rx_err` or a gap longer than `PKT_GAP_CYC` drops the partial packet and sets the index to 0.
- Packet decode:
  - b0: [0] L, [1] R, [2] M buttons; [4] X sign; [5] Y sign; [6] X overflow; [7] Y overflow.
  - dx = {b0[4], b1}, 9-bit two's complement.
  - dy = {b0[5], b2}, 9-bit two's complement.
- Position update:
  - x ← clamp(x + dx, 0, X_MAX).
  - y ← clamp(y − dy, 0, Y_MAX), so screen Y grows downward.
  - Arithmetic is done at 10-bit signed width.
  - If an axis's overflow bit is set, that axis's delta is treated as 0.
  - Buttons update on every complete packet.
- Register map (read-only):
  - 00: {5'b0, M, R, L}
  - 01: x
  - 10: y
  - 11: {6'b0, err, ready}
- Reset values:
  - `data`, `dav`, `tx_req`, `tx_byte`, `ready`, `err`, buttons: 0.
  - x = X_MAX/2, y = Y_MAX/2 (integer division).
  - State = SEND_RST, byte index = 0, counters cleared.

## Timing
- `tx_req` asserts on the first edge after `rst` deasserts, provided `tx_busy`=0.
- `tx_req` is high for exactly 1 cycle. It is never reasserted before `tx_done`.
- The edge that samples `rx_valid` of byte 2 updates x, y and buttons, and sets `dav`. `dav` is high for the following cycle only.
- Read latency is 1: the edge with `io_cs`=1 loads `data` ← reg[`addr`]. `data` holds its value while `io_cs`=0.
- A read on the same edge as a packet update returns the pre-update value.
- `rx_valid` arriving in a SEND state is ignored.
- `rx_valid` and a timeout on the same edge: the byte wins.
- `rst` low mid-transfer: returns to reset values on the next edge. Any in-flight transceiver frame is the transceiver's concern.

## Structure
- Shared package `ps2_pkg` holds:
  - Command/response constants: CMD_RESET 0xFF, CMD_ENABLE 0xF4, RSP_ACK 0xFA, RSP_RESEND 0xFE, RSP_BAT_OK 0xAA, MOUSE_ID 0x00.
  - State enum.
  - Register address constants.
- One sub-module: `ps2_axis_accum`, a saturating signed-delta accumulator (pos, 9-bit delta, negate, max). It is instantiated once for X and once for Y.

## Test plan
- Happy init: transceiver returns FA, AA, 00, then FA → `tx_byte` sequence FF then F4, `ready`=1. A read at addr 11 returns 0x01.
- Resend: FE answers the first FF → FF sent twice, init completes normally, `err`=0.
- Timeout (TIMEOUT_CYC=1000): no reply after FF → at cycle ~1000 FF is resent and `err`=1. Completing init clears it.
- Packet 0x09, 0x05, 0x03 from reset centre (127,127) → `dav` pulse; x=132, y=124; addr 00 reads 0x01.
- Clamp and overflow:
  - Packet 0x18, 0x80, 0x00 at x=10 → x=0.
  - Packet 0x48, 0x7F, 0x00 → x unchanged (X overflow).
- Resync and gap:
  - Stray byte 0x05 then packet 0x08, 0x01, 0x01 → one `dav` and a correct update.
  - Byte 0x08, then idle for PKT_GAP_CYC+1 cycles, then a full packet → exactly one `dav`.
